// File: rtl/spi_slave_rx_if.sv
// rtl/spi_slave_rx_if.sv - SPI slave receiver pin and strobe bundle; SPI_RX_MISO_EN adds the MISO side
interface spi_slave_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  spi_sclk;
    logic                  spi_mosi;
    logic                  spi_cs_n;
    logic                  data_bit;
    logic                  bit_valid;
    logic [DATA_WIDTH-1:0] data_byte;
    logic                  byte_valid;
    logic                  busy;
    logic                  frame_err;
`ifdef SPI_RX_MISO_EN
    logic [DATA_WIDTH-1:0] tx_byte;
    logic                  spi_miso;
`endif

    modport slave (
        input  spi_sclk, spi_mosi, spi_cs_n,
        output data_bit, bit_valid, data_byte, byte_valid, busy, frame_err
`ifdef SPI_RX_MISO_EN
        , input tx_byte, output spi_miso
`endif
    );

    modport master (
        output spi_sclk, spi_mosi, spi_cs_n,
        input  data_bit, bit_valid, data_byte, byte_valid, busy, frame_err
`ifdef SPI_RX_MISO_EN
        , output tx_byte, input spi_miso
`endif
    );
endinterface

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 slave receiver with bit/word strobes; SPI_RX_MISO_EN adds a MISO transmitter
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input logic          clk,
    input logic          rst,
    spi_slave_rx_if.slave bus
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_prev;
    logic                   sclk_s, mosi_s, cs_s, rise;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [DATA_WIDTH-2:0]  sr;
    logic [DATA_WIDTH-1:0]  sr_full;
    logic                   data_bit_q, bit_valid_q, byte_valid_q, busy_q, frame_err_q;
    logic [DATA_WIDTH-1:0]  data_byte_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev;

    // Only DATA_WIDTH-1 bits of history are kept; the incoming bit completes the word.
    always_comb begin
        sr_full = '0;
        if (MSB_FIRST) sr_full = {sr, mosi_s};
        else           sr_full = {mosi_s, sr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sr           <= '0;
            data_bit_q   <= 1'b0;
            bit_valid_q  <= 1'b0;
            data_byte_q  <= '0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bit_valid_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cs_s) begin
                        state  <= ACTIVE;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
                ACTIVE: begin
                    // Chip-select release takes priority over a coincident SCLK rise.
                    if (cs_s) begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= (cnt != '0);
                        cnt         <= '0;
                    end else if (rise) begin
                        data_bit_q  <= mosi_s;
                        bit_valid_q <= 1'b1;
                        sr          <= MSB_FIRST ? sr_full[DATA_WIDTH-2:0] : sr_full[DATA_WIDTH-1:1];
                        if (cnt == LAST) begin
                            data_byte_q  <= sr_full;
                            byte_valid_q <= 1'b1;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_bit   = data_bit_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.data_byte  = data_byte_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_err  = frame_err_q;

`ifdef SPI_RX_MISO_EN
    logic                  fall;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic                  miso_q;
    logic                  word_done;

    assign fall = ~sclk_s & sclk_prev;

    // MISO changes on SCLK falls; a completed word makes the next fall reload tx_byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr     <= '0;
            miso_q    <= 1'b0;
            word_done <= 1'b0;
        end else if (state == IDLE) begin
            word_done <= 1'b0;
            if (!cs_s) begin
                tx_sr  <= bus.tx_byte;
                miso_q <= MSB_FIRST ? bus.tx_byte[DATA_WIDTH-1] : bus.tx_byte[0];
            end else begin
                miso_q <= 1'b0;
            end
        end else if (cs_s) begin
            miso_q    <= 1'b0;
            word_done <= 1'b0;
        end else begin
            if (rise && cnt == LAST) word_done <= 1'b1;
            if (fall) begin
                word_done <= 1'b0;
                if (word_done) begin
                    tx_sr  <= bus.tx_byte;
                    miso_q <= MSB_FIRST ? bus.tx_byte[DATA_WIDTH-1] : bus.tx_byte[0];
                end else begin
                    tx_sr  <= MSB_FIRST ? (tx_sr << 1) : (tx_sr >> 1);
                    miso_q <= MSB_FIRST ? tx_sr[DATA_WIDTH-2] : tx_sr[1];
                end
            end
        end
    end

    assign bus.spi_miso = miso_q;
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - randomized self-checking bench for spi_slave_rx, MSB-first and LSB-first instances on shared pins
module tb_spi_slave_rx;
    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;
`ifdef SPI_RX_MISO_EN
    localparam int HMIN = 4;
    localparam int HMAX = 6;
`else
    localparam int HMIN = 2;
    localparam int HMAX = 5;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
    logic [W-1:0] tx_byte = '0;

    always #5 clk = ~clk;

    spi_slave_rx_if #(.DATA_WIDTH(W)) bus0 ();
    spi_slave_rx_if #(.DATA_WIDTH(W)) bus1 ();

    assign bus0.spi_sclk = sclk;
    assign bus0.spi_mosi = mosi;
    assign bus0.spi_cs_n = cs_n;
    assign bus1.spi_sclk = sclk;
    assign bus1.spi_mosi = mosi;
    assign bus1.spi_cs_n = cs_n;
`ifdef SPI_RX_MISO_EN
    assign bus0.tx_byte = tx_byte;
    assign bus1.tx_byte = tx_byte;
`endif

    spi_slave_rx #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus0));
    spi_slave_rx #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        int           due;
        logic         b;
        bit           word;
        logic [W-1:0] wm;
        logic [W-1:0] wl;
    } exp_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    bit           in_reset = 1'b1;
    logic         cs_d0 = 1'b1, cs_d1 = 1'b1, cs_d2 = 1'b1;
    exp_t         exp_q[$];
    int           err_q[$];
    logic [W-1:0] last_m = '0, last_l = '0;
    int           nb = 0, nw = 0, ne = 0;
    logic [W-1:0] cap_m[4];
    logic [W-1:0] cap_l[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Pin history: a change driven after edge c is first seen by the design on edge c+1.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (in_reset) begin
            cs_d0 = 1'b1; cs_d1 = 1'b1; cs_d2 = 1'b1;
        end else begin
            cs_d2 = cs_d1; cs_d1 = cs_d0; cs_d0 = cs_n;
        end
    end

    initial forever begin : cmp
        exp_t e;
        bit   hit, ehit, wnow;
        @(negedge clk);
        if (!in_reset) begin
            hit  = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            ehit = (err_q.size() > 0) && (err_q[0] == cyc);
            e    = '{default: '0};
            if (hit) e = exp_q.pop_front();
            if (ehit) void'(err_q.pop_front());
            wnow = hit && e.word;
            if (wnow) begin
                last_m = e.wm;
                last_l = e.wl;
            end
            check("bit_valid_msb", bus0.bit_valid, hit);
            check("bit_valid_lsb", bus1.bit_valid, hit);
            if (hit) begin
                check("data_bit_msb", bus0.data_bit, e.b);
                check("data_bit_lsb", bus1.data_bit, e.b);
            end
            check("byte_valid_msb", bus0.byte_valid, wnow);
            check("byte_valid_lsb", bus1.byte_valid, wnow);
            check("data_byte_msb", bus0.data_byte, last_m);
            check("data_byte_lsb", bus1.data_byte, last_l);
            check("frame_err_msb", bus0.frame_err, ehit);
            check("frame_err_lsb", bus1.frame_err, ehit);
            check("busy_msb", bus0.busy, !cs_d2);
            check("busy_lsb", bus1.busy, !cs_d2);
`ifdef SPI_RX_MISO_EN
            if (cs_d2) begin
                check("miso_idle_msb", bus0.spi_miso, 1'b0);
                check("miso_idle_lsb", bus1.spi_miso, 1'b0);
            end
`endif
            if (bus0.bit_valid)  nb++;
            if (bus0.byte_valid) nw++;
            if (bus0.frame_err)  ne++;
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bit"},   {bus0.data_bit, bus1.data_bit}, 2'b00);
        check({tag, "_bv"},    {bus0.bit_valid, bus1.bit_valid}, 2'b00);
        check({tag, "_byte"},  {bus0.data_byte, bus1.data_byte}, '0);
        check({tag, "_wv"},    {bus0.byte_valid, bus1.byte_valid}, 2'b00);
        check({tag, "_busy"},  {bus0.busy, bus1.busy}, 2'b00);
        check({tag, "_ferr"},  {bus0.frame_err, bus1.frame_err}, 2'b00);
`ifdef SPI_RX_MISO_EN
        check({tag, "_miso"},  {bus0.spi_miso, bus1.spi_miso}, 2'b00);
`endif
    endtask

    // Sends n bits, first bit = pat[n-1]; tx_swap >= 0 replaces tx_byte after the first rise.
    task automatic send_frame(input logic [63:0] pat, input int n, input int tx_swap, input bit close);
        logic         bits[64];
        logic         cm_bits[W];
        logic         cl_bits[W];
        logic [W-1:0] wm, wl, exp_tx;
        exp_t         e;
        int           k0;
        clocks(1);
        cs_n   = 1'b0;
        exp_tx = tx_byte;
        clocks($urandom_range(HMAX, SYNC + 2));
        for (int k = 0; k < n; k++) begin
            bits[k] = pat[n-1-k];
            mosi = bits[k];
            clocks(1);
`ifdef SPI_RX_MISO_EN
            cm_bits[k % W] = bus0.spi_miso;
            cl_bits[k % W] = bus1.spi_miso;
`else
            cm_bits[k % W] = 1'b0;
            cl_bits[k % W] = 1'b0;
`endif
            sclk = 1'b1;
            e = '{due: cyc + LAT, b: bits[k], word: 1'b0, wm: '0, wl: '0};
            if (k % W == W - 1) begin
                k0 = k - (W - 1);
                wm = '0;
                wl = '0;
                for (int j = 0; j < W; j++) begin
                    wm = wm | (W'(bits[k0+j]) << (W - 1 - j));
                    wl = wl | (W'(bits[k0+j]) << j);
                end
                e.word = 1'b1; e.wm = wm; e.wl = wl;
`ifdef SPI_RX_MISO_EN
                wm = '0;
                wl = '0;
                for (int j = 0; j < W; j++) begin
                    wm = wm | (W'(cm_bits[j]) << (W - 1 - j));
                    wl = wl | (W'(cl_bits[j]) << j);
                end
                check("miso_word_msb", wm, exp_tx);
                check("miso_word_lsb", wl, exp_tx);
                if (k / W < 4) begin
                    cap_m[k/W] = wm;
                    cap_l[k/W] = wl;
                end
`endif
            end
            exp_q.push_back(e);
            if (k == 0 && tx_swap >= 0) tx_byte = W'(tx_swap);
            if (k % W == W - 1) exp_tx = tx_byte;
            clocks($urandom_range(HMAX, HMIN));
            sclk = 1'b0;
            clocks($urandom_range(HMAX, HMIN) - 1);
        end
        if (close) begin
            clocks($urandom_range(6, 3));
            cs_n = 1'b1;
            if (n % W != 0) err_q.push_back(cyc + LAT);
            clocks($urandom_range(8, 4));
        end
    endtask

    int b0, w0, e0;
    task automatic snap();
        b0 = nb; w0 = nw; e0 = ne;
    endtask

    initial begin
        // Reset state
        clocks(3);
        #1;
        check_zero("reset");
        rst = 1'b0;
        clocks(2);
        in_reset = 1'b0;

        // SCLK noise with CS_n high
        snap();
        for (int i = 0; i < 32; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            clocks(HMIN);
        end
        sclk = 1'b0;
        clocks(6);
        check("noise_bits", nb - b0, 0);
        check("noise_busy", bus0.busy, 1'b0);

        // Single word 0xA5
        snap();
        send_frame(64'hA5, 8, -1, 1'b1);
        check("a5_bits", nb - b0, 8);
        check("a5_words", nw - w0, 1);
        check("a5_err", ne - e0, 0);
        check("a5_byte_msb", bus0.data_byte, 8'hA5);
        check("a5_byte_lsb", bus1.data_byte, 8'hA5);

        // Back-to-back 0x3C, 0xFF
        snap();
        send_frame(64'h3CFF, 16, -1, 1'b1);
        check("b2b_words", nw - w0, 2);
        check("b2b_err", ne - e0, 0);
        check("b2b_byte", bus0.data_byte, 8'hFF);

        // Abort after 5 bits, then 0x81
        snap();
        send_frame(64'h16, 5, -1, 1'b1);
        check("abort_words", nw - w0, 0);
        check("abort_err", ne - e0, 1);
        check("abort_byte", bus0.data_byte, 8'hFF);
        send_frame(64'h81, 8, -1, 1'b1);
        check("after_abort_msb", bus0.data_byte, 8'h81);
        check("after_abort_lsb", bus1.data_byte, 8'h81);

        // Bits 1,0,0,0,0,0,0,0
        send_frame(64'h80, 8, -1, 1'b1);
        check("order_msb", bus0.data_byte, 8'h80);
        check("order_lsb", bus1.data_byte, 8'h01);

        // Reset mid-frame
        send_frame(64'h52D, 11, -1, 1'b0);
        clocks(LAT + 2);
        check("pre_reset_byte", bus0.data_byte, 8'hA5);
        #2;
        in_reset = 1'b1;
        rst = 1'b1;
        #1;
        check_zero("midreset");
        exp_q.delete();
        err_q.delete();
        last_m = '0;
        last_l = '0;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        clocks(3);
        rst = 1'b0;
        clocks(3);
        in_reset = 1'b0;
        snap();
        send_frame(64'h5C, 8, -1, 1'b1);
        check("post_reset_err", ne - e0, 0);
        check("post_reset_byte", bus0.data_byte, 8'h5C);

`ifdef SPI_RX_MISO_EN
        // MISO: 0x5A returned, then the reloaded 0x96
        tx_byte = 8'h5A;
        send_frame(64'hC3C3, 16, 'h96, 1'b1);
        check("miso_w0_msb", cap_m[0], 8'h5A);
        check("miso_w0_lsb", cap_l[0], 8'h5A);
        check("miso_w1_msb", cap_m[1], 8'h96);
        check("miso_w1_lsb", cap_l[1], 8'h96);
        check("miso_rx_byte", bus0.data_byte, 8'hC3);
`endif

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            tx_byte = W'($urandom);
            send_frame({$urandom, $urandom}, $urandom_range(24, 1), -1, 1'b1);
        end

        clocks(10);
        check("pending_bits", exp_q.size(), 0);
        check("pending_errs", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected end of stimulus");
        $fatal(1);
    end
endmodule
